sm_accumulator: RTL and testbench

//  Sequential sign-magnitude accumulator: sums a packet of O_VEC-bit sign-magnitude terms
//  (products plus bias) into one neuron pre-activation result. Sits between the multiplier

---
 rtl/sm_accumulator.sv | 122 ++++++++++++
 tb/tb_sm_accumulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_accumulator.sv
// Sequential sign-magnitude accumulator: sums a framed packet of sign-magnitude terms
// into one result, with overflow detection, saturate/wrap mode and an output handshake.
module sm_accumulator #(
    parameter int unsigned O_VEC  = 21,
    parameter bit          SAT_EN = 1'b1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [O_VEC-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [O_VEC-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int unsigned M = O_VEC - 1;

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e           state_q, state_d;
    logic [O_VEC-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             term_sign;
    logic [M-1:0]     term_mag;
    logic             acc_sign;
    logic [M-1:0]     acc_mag;
    logic [M:0]       mag_sum;
    logic             sum_sign;
    logic [M-1:0]     sum_mag;
    logic             sum_ovf;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready  = (state_q != StDone);
    assign out_valid = (state_q == StDone);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign out_cnt   = cnt_q;
    assign accept    = in_valid && in_ready;

    // A -0 term is folded to +0 before it touches the sum.
    assign term_mag  = in_data[M-1:0];
    assign term_sign = in_data[O_VEC-1] && (term_mag != '0);
    assign acc_sign  = acc_q[O_VEC-1];
    assign acc_mag   = acc_q[M-1:0];
    assign mag_sum   = {1'b0, acc_mag} + {1'b0, term_mag};
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        sum_sign = 1'b0;
        sum_mag  = '0;
        sum_ovf  = 1'b0;
        if (acc_sign == term_sign) begin
            sum_sign = acc_sign;
            sum_ovf  = mag_sum[M];
            sum_mag  = (mag_sum[M] && SAT_EN) ? '1 : mag_sum[M-1:0];
        end else if (acc_mag > term_mag) begin
            sum_sign = acc_sign;
            sum_mag  = acc_mag - term_mag;
        end else if (term_mag > acc_mag) begin
            sum_sign = term_sign;
            sum_mag  = term_mag - acc_mag;
        end
        // A wrapped sum can land exactly on zero; keep it positive.
        if (sum_mag == '0) begin
            sum_sign = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d   = {term_sign, term_mag};
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? StDone : StAcc;
                end
            end
            StAcc: begin
                if (accept) begin
                    acc_d   = {sum_sign, sum_mag};
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_q || sum_ovf;
                    state_d = in_last ? StDone : StAcc;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed scoreboard bench for sm_accumulator; a saturating and a wrapping instance
// share one stimulus stream and are checked against their own expected sums.
module tb_sm_accumulator;

    localparam int unsigned O_VEC = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [O_VEC-1:0] in_data;
    logic             in_last;
    logic             out_ready;

    logic             in_ready_s, out_valid_s, out_ovf_s;
    logic [O_VEC-1:0] out_data_s;
    logic [CNT_W-1:0] out_cnt_s;
    logic             in_ready_w, out_valid_w, out_ovf_w;
    logic [O_VEC-1:0] out_data_w;
    logic [CNT_W-1:0] out_cnt_w;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] dsat;
        logic [7:0] dwrap;
        logic       ovf;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sm_accumulator #(.O_VEC(O_VEC), .SAT_EN(1'b1), .CNT_W(CNT_W)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .out_ovf   (out_ovf_s),
        .out_cnt   (out_cnt_s)
    );

    sm_accumulator #(.O_VEC(O_VEC), .SAT_EN(1'b0), .CNT_W(CNT_W)) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .out_data  (out_data_w),
        .out_ovf   (out_ovf_w),
        .out_cnt   (out_cnt_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] ds, input logic [7:0] dw, input logic ovf,
                        input logic [7:0] cnt);
        exp_t e;
        e.dsat  = ds;
        e.dwrap = dw;
        e.ovf   = ovf;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    // Present one term, wait (bounded) for in_ready, and return 1 time unit after the accept edge.
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'(in_ready_s), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called right after the last term is accepted; holds DONE for 'hold' cycles, then drains.
    task automatic collect(input int hold);
        exp_t e;
        chk("latency_valid", 32'(out_valid_s), 32'd1);
        chk("latency_valid_w", 32'(out_valid_w), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("data_sat", 32'(out_data_s), 32'(e.dsat));
            chk("data_wrap", 32'(out_data_w), 32'(e.dwrap));
            chk("ovf_sat", 32'(out_ovf_s), 32'(e.ovf));
            chk("ovf_wrap", 32'(out_ovf_w), 32'(e.ovf));
            chk("cnt_sat", 32'(out_cnt_s), 32'(e.cnt));
            chk("cnt_wrap", 32'(out_cnt_w), 32'(e.cnt));
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                in_data  = 8'h11;
                @(negedge clk);
                chk("bp_in_ready", 32'(in_ready_s), 32'd0);
                chk("bp_out_valid", 32'(out_valid_s), 32'd1);
                chk("bp_data_stable", 32'(out_data_s), 32'(e.dsat));
                chk("bp_cnt_stable", 32'(out_cnt_s), 32'(e.cnt));
                @(posedge clk);
                #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_out_valid", 32'(out_valid_s), 32'd0);
        chk("drain_in_ready", 32'(in_ready_s), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid_s), 32'd0);
        chk("rst_in_ready", 32'(in_ready_s), 32'd1);
        chk("rst_out_data", 32'(out_data_s), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt_s), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf_s), 32'd0);

        // +5, -3, +10 -> +12
        send(8'h05, 1'b0);
        send(8'h83, 1'b0);
        push(8'h0C, 8'h0C, 1'b0, 8'd3);
        send(8'h0A, 1'b1);
        collect(0);

        // +7, -7 -> +0; single -0 -> +0
        send(8'h07, 1'b0);
        push(8'h00, 8'h00, 1'b0, 8'd2);
        send(8'h87, 1'b1);
        collect(0);
        push(8'h00, 8'h00, 1'b0, 8'd1);
        send(8'h80, 1'b1);
        collect(0);

        // +100, +100, -50: saturate -> 77, wrap -> 22
        send(8'h64, 1'b0);
        send(8'h64, 1'b0);
        push(8'h4D, 8'h16, 1'b1, 8'd3);
        send(8'hB2, 1'b1);
        collect(0);

        // Backpressure for 5 cycles with in_valid high, then a single-term packet
        send(8'h01, 1'b0);
        push(8'h03, 8'h03, 1'b0, 8'd2);
        send(8'h02, 1'b1);
        collect(5);
        push(8'h85, 8'h85, 1'b0, 8'd1);
        send(8'h85, 1'b1);
        collect(0);

        // Reset mid-packet discards the partial sum
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid_s), 32'd0);
        chk("midrst_in_ready", 32'(in_ready_s), 32'd1);
        chk("midrst_out_cnt", 32'(out_cnt_s), 32'd0);
        send(8'h87, 1'b0);
        push(8'h8F, 8'h8F, 1'b0, 8'd2);
        send(8'h88, 1'b1);
        collect(0);

        // Gapped input: four +1 terms with idle cycles between them
        for (int i = 0; i < 3; i++) begin
            send(8'h01, 1'b0);
            idle(1);
        end
        push(8'h04, 8'h04, 1'b0, 8'd4);
        send(8'h01, 1'b1);
        collect(0);

        // 256 terms of -0: counter stops at 255, sum stays +0
        for (int i = 0; i < 255; i++) send(8'h80, 1'b0);
        push(8'h00, 8'h00, 1'b0, 8'd255);
        send(8'h80, 1'b1);
        collect(0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
